// File: rtl/return_addr_stack.sv
// rtl/return_addr_stack.sv - Return-address stack for subroutine call/return (optional RAS_WRAP_OVERWRITE_EN)
// Define RAS_WRAP_OVERWRITE_EN to let a push while full overwrite the oldest entry circularly.
module return_addr_stack #(
  parameter int DEPTH = 8,
  parameter int AW    = 12
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [AW-1:0]              pushaddr_i,
  input  logic                       clr_err_i,
  output logic [AW-1:0]              stackaddr_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] sp;
  logic [PW-1:0] top;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          push_only;
  logic          replace;

  assign top   = sp - PW'(1);
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A push paired with a pop on an empty stack has nothing to replace, so it acts as a plain push.
  assign push_only = push_i && (!pop_i || empty);
  assign replace   = push_i && pop_i && !empty;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      sp          <= '0;
      count       <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (clr_err_i) begin
        overflow_o  <= 1'b0;
        underflow_o <= 1'b0;
      end
      if (push_only) begin
        if (!full) begin
          mem[sp] <= pushaddr_i;
          sp      <= sp + PW'(1);
          count   <= count + CW'(1);
        end else begin
          overflow_o <= 1'b1;
`ifdef RAS_WRAP_OVERWRITE_EN
          mem[sp] <= pushaddr_i;
          sp      <= sp + PW'(1);
`endif
        end
      end else if (replace) begin
        mem[top] <= pushaddr_i;
      end else if (pop_i) begin
        if (empty) begin
          underflow_o <= 1'b1;
        end else begin
          sp    <= top;
          count <= count - CW'(1);
        end
      end
    end
  end

  assign stackaddr_o = empty ? '0 : mem[top];
  assign empty_o     = empty;
  assign full_o      = full;
  assign count_o     = count;

endmodule

// File: tb/tb_return_addr_stack.sv
// tb/tb_return_addr_stack.sv - Directed self-checking bench for return_addr_stack
module tb_return_addr_stack;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        push_i;
  logic        pop_i;
  logic [11:0] pushaddr_i;
  logic        clr_err_i;
  logic [11:0] stackaddr_o;
  logic        empty_o;
  logic        full_o;
  logic [3:0]  count_o;
  logic        overflow_o;
  logic        underflow_o;

  int errors = 0;
  int checks = 0;

  return_addr_stack #(.DEPTH(8), .AW(12)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push_i),
    .pop_i       (pop_i),
    .pushaddr_i  (pushaddr_i),
    .clr_err_i   (clr_err_i),
    .stackaddr_o (stackaddr_o),
    .empty_o     (empty_o),
    .full_o      (full_o),
    .count_o     (count_o),
    .overflow_o  (overflow_o),
    .underflow_o (underflow_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    push_i     = 1'b0;
    pop_i      = 1'b0;
    clr_err_i  = 1'b0;
    pushaddr_i = 12'h000;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic push_val(input logic [11:0] a);
    push_i = 1'b1; pushaddr_i = a;
    tick();
    push_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count_o); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty_o); end
    checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full_o); end
    checks++; if (stackaddr_o !== 12'h000) begin errors++; $display("FAIL reset_top got %h want 000", stackaddr_o); end
    checks++; if (overflow_o !== 1'b0 || underflow_o !== 1'b0) begin
      errors++; $display("FAIL reset_flags got ov=%b un=%b want 0 0", overflow_o, underflow_o);
    end
  endtask

  task automatic test_lifo();
    logic [11:0] exp_vals [3];
    exp_vals[0] = 12'h033; exp_vals[1] = 12'h022; exp_vals[2] = 12'h011;
    do_reset();
    push_val(12'h011);
    push_val(12'h022);
    push_val(12'h033);
    checks++; if (count_o !== 4'd3) begin errors++; $display("FAIL lifo_count got %0d want 3", count_o); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (stackaddr_o !== exp_vals[i]) begin
        errors++; $display("FAIL lifo_top%0d got %h want %h", i, stackaddr_o, exp_vals[i]);
      end
      pop_i = 1'b1;
      tick();
      pop_i = 1'b0;
    end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL lifo_empty got %b want 1", empty_o); end
    checks++; if (underflow_o !== 1'b0) begin errors++; $display("FAIL lifo_underflow got %b want 0", underflow_o); end
  endtask

  task automatic test_fill_overflow();
    logic [11:0] exp_top;
    do_reset();
    for (int i = 0; i < 8; i++) push_val(12'h100 + 12'(i));
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL fill_no_ovf got %b want 0", overflow_o); end
    push_val(12'h1FF);
    checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", full_o); end
    checks++; if (count_o !== 4'd8) begin errors++; $display("FAIL fill_count got %0d want 8", count_o); end
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL fill_overflow got %b want 1", overflow_o); end
    for (int i = 0; i < 8; i++) begin
`ifdef RAS_WRAP_OVERWRITE_EN
      exp_top = (i == 0) ? 12'h1FF : 12'h107 - 12'(i - 1);
`else
      exp_top = 12'h107 - 12'(i);
`endif
      checks++; if (stackaddr_o !== exp_top) begin
        errors++; $display("FAIL fill_pop%0d got %h want %h", i, stackaddr_o, exp_top);
      end
      pop_i = 1'b1;
      tick();
      pop_i = 1'b0;
    end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL fill_drained got %b want 1", empty_o); end
  endtask

  task automatic test_underflow_clear();
    do_reset();
    pop_i = 1'b1;
    tick();
    pop_i = 1'b0;
    checks++; if (underflow_o !== 1'b1) begin errors++; $display("FAIL unf_set got %b want 1", underflow_o); end
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL unf_count got %0d want 0", count_o); end
    tick();
    checks++; if (underflow_o !== 1'b1) begin errors++; $display("FAIL unf_sticky got %b want 1", underflow_o); end
    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0;
    checks++; if (underflow_o !== 1'b0) begin errors++; $display("FAIL unf_clear got %b want 0", underflow_o); end
    pop_i = 1'b1; clr_err_i = 1'b1;
    tick();
    pop_i = 1'b0; clr_err_i = 1'b0;
    checks++; if (underflow_o !== 1'b1) begin errors++; $display("FAIL unf_set_wins got %b want 1", underflow_o); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    push_val(12'hA00);
    push_i = 1'b1; pop_i = 1'b1; pushaddr_i = 12'hB00;
    #1;
    checks++; if (stackaddr_o !== 12'hA00) begin errors++; $display("FAIL simul_old_top got %h want A00", stackaddr_o); end
    tick();
    push_i = 1'b0; pop_i = 1'b0;
    checks++; if (stackaddr_o !== 12'hB00) begin errors++; $display("FAIL simul_new_top got %h want B00", stackaddr_o); end
    checks++; if (count_o !== 4'd1) begin errors++; $display("FAIL simul_count got %0d want 1", count_o); end
    do_reset();
    push_i = 1'b1; pop_i = 1'b1; pushaddr_i = 12'hC00;
    tick();
    push_i = 1'b0; pop_i = 1'b0;
    checks++; if (count_o !== 4'd1 || stackaddr_o !== 12'hC00) begin
      errors++; $display("FAIL simul_empty got count=%0d top=%h want 1 C00", count_o, stackaddr_o);
    end
    checks++; if (underflow_o !== 1'b0) begin errors++; $display("FAIL simul_empty_unf got %b want 0", underflow_o); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    push_val(12'h321);
    push_val(12'h322);
    push_val(12'h323);
    rst_ni = 1'b0; push_i = 1'b1; pushaddr_i = 12'h777;
    tick();
    rst_ni = 1'b1; push_i = 1'b0;
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL midrst_count got %0d want 0", count_o); end
    checks++; if (stackaddr_o !== 12'h000) begin errors++; $display("FAIL midrst_top got %h want 000", stackaddr_o); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL midrst_empty got %b want 1", empty_o); end
  endtask

  initial begin
    idle_inputs();
    rst_ni = 1'b0;
    test_reset();
    test_lifo();
    test_fill_overflow();
    test_underflow_clear();
    test_simultaneous();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/return_addr_stack.md
Name: return_addr_stack

Overview:
- Hardware return-address stack for the Gumnut core's subroutine call/return path.
- On a jsb/call, the control unit pushes the return address (current PC + 1).
- On a ret, the control unit pops; the top-of-stack is presented continuously on stackaddr_o, which feeds the next-PC selector's stack-address input (selected by PC operation 4'b1010).
- Tracks fill level and flags overflow/underflow as sticky error bits for the interrupt/exception logic.

Parameters:
- DEPTH, 8, number of return-address entries; power of two, min 2.
- AW, 12, address width in bits; matches the 12-bit instruction address space.

Ports:
- clk_i  input  1  core clock; all state updates on rising edge.
- rst_ni  input  1  synchronous, active-low reset.
- push_i  input  1  push pushaddr_i this cycle (call).
- pop_i  input  1  pop top entry this cycle (return).
- pushaddr_i  input  AW  return address to store.
- clr_err_i  input  1  clears sticky overflow_o/underflow_o.
- stackaddr_o  output  AW  current top-of-stack entry; combinational from state.
- empty_o  output  1  count == 0.
- full_o  output  1  count == DEPTH.
- count_o  output  $clog2(DEPTH)+1  number of valid entries.
- overflow_o  output  1  sticky: push attempted while full.
- underflow_o  output  1  sticky: pop attempted while empty.

Behaviour:
- Storage: DEPTH x AW register array, write pointer sp (log2 DEPTH bits, wraps mod DEPTH), count register.
- stackaddr_o = mem[sp-1] when count > 0; 12'h000 (all zeros) when empty. Zero-latency so the next-PC selector can use it in the same cycle pop_i is asserted.
- Reset (rst_ni low at a clock edge):
  - sp = 0, count = 0, all entries = 0, overflow_o = underflow_o = 0.
  - Reset overrides push/pop/clr in the same cycle.
  - A reset mid-sequence discards all entries.
- Push only, not full: mem[sp] <= pushaddr_i, sp <= sp+1, count <= count+1.
- Pop only, not empty: sp <= sp-1, count <= count-1. The entry is not cleared; it is simply no longer valid.
- Push and pop together, count > 0: replace the top. mem[sp-1] <= pushaddr_i; sp and count unchanged. stackaddr_o shows the old top during that cycle.
- Push and pop together, empty: treated as push only. underflow_o is not set.
- Pop while empty: no state change; underflow_o <= 1.
- Push while full, without the optional feature: push ignored, stack unchanged; overflow_o <= 1.
- Sticky flags:
  - Cleared by clr_err_i = 1 at a clock edge.
  - If a new error and clr_err_i occur in the same cycle, the flag is set (set wins).
- count_o, empty_o and full_o are derived from the count register; they update the cycle after the push/pop edge.
- No handshake or stall: every asserted request is resolved in a single cycle.

Optional Feature:
- Macro: RAS_WRAP_OVERWRITE_EN.
- Defined: push while full (push only) is accepted circularly.
  - mem[sp] <= pushaddr_i, sp <= sp+1; count stays DEPTH.
  - The oldest entry is lost.
  - overflow_o is still set, so software can detect corrupted deep returns.
- Not defined: push while full is ignored, as described in Behaviour.
- All other behaviour is identical in both builds.

Test Plan:
- Reset then idle:
  - Hold rst_ni = 0 for 2 cycles, release.
  - Required: count_o = 0, empty_o = 1, full_o = 0, stackaddr_o = 12'h000, both flags 0.
- LIFO order:
  - Push 12'h011, 12'h022, 12'h033 on consecutive cycles; then pop 3 times.
  - Required: stackaddr_o reads 12'h033, 12'h022, 12'h011 before each pop; empty_o = 1 afterwards.
- Fill and overflow (default build):
  - Push 8 values 12'h100..12'h107, then push 12'h1FF.
  - Required: full_o = 1, count_o = 8, overflow_o = 1, stackaddr_o = 12'h107.
  - With RAS_WRAP_OVERWRITE_EN defined: stackaddr_o = 12'h1FF; popping 8 times returns 12'h1FF, 12'h107..12'h101.
- Underflow and clear:
  - Pop on empty. Required: underflow_o = 1, count_o stays 0.
  - Assert clr_err_i for one cycle. Required: underflow_o = 0.
  - Assert pop on empty and clr_err_i together. Required: underflow_o = 1.
- Simultaneous push/pop:
  - Push 12'hA00, then push 12'hB00 with pop in the same cycle.
  - Required: stackaddr_o = 12'hA00 during that cycle, 12'hB00 after; count_o = 1.
- Reset mid-operation:
  - Push 3 entries, assert rst_ni = 0 together with push_i.
  - Required: next cycle count_o = 0, stackaddr_o = 12'h000; the push is discarded.
